// File: rtl/pc_branch_unit.sv
// PC register, branch resolver, link capture and 2-bit per-PC branch history table.
// Optional statistics counters are built when PC_BRANCH_STATS_EN is defined.
module pc_branch_unit #(
   parameter int              PC_W      = 32,
   parameter int              BHT_DEPTH = 16,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter logic [PC_W-1:0] EXC_VEC   = 'h0000_00FF
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic [5:0]      opcode_i,
   input  logic [4:0]      rt_i,
   input  logic            zero_i,
   input  logic            lt_i,
   input  logic            eq_i,
   input  logic            gt_i,
   input  logic            pc_write_i,
   input  logic            pc_cond_eq_i,
   input  logic            pc_cond_ne_i,
   input  logic            pc_cond_i,
   input  logic            exc_req_i,
   input  logic [PC_W-1:0] next_pc_i,
   output logic [PC_W-1:0] pc_o,
   output logic            take_o,
   output logic            link_we_o,
   output logic [PC_W-1:0] link_pc_o,
   output logic            pred_taken_o,
   output logic            mispredict_o,
   output logic [31:0]     stat_branches_o,
   output logic [31:0]     stat_mispred_o
);
   localparam int IW = $clog2(BHT_DEPTH);

   logic [PC_W-1:0] pc_q, pc_d;
   logic            link_we_q, link_we_d;
   logic [PC_W-1:0] link_pc_q, link_pc_d;
   logic            mispred_q, mispred_d;
   logic [1:0]      bht_q [BHT_DEPTH];
   logic [1:0]      bht_cur, bht_upd_d;
   logic [IW-1:0]   idx;
   logic            cond, is_br, resolve;

   assign idx     = pc_q[IW+1:2];
   assign bht_cur = bht_q[idx];

   // is_br: enable asserted for a recognised branch op/rt; cond: that branch is taken
   always_comb begin
      cond  = 1'b0;
      is_br = 1'b0;
      case (opcode_i)
         6'd4: begin is_br = pc_cond_eq_i; cond = pc_cond_eq_i & zero_i;  end
         6'd5: begin is_br = pc_cond_ne_i; cond = pc_cond_ne_i & ~zero_i; end
         6'd7: begin is_br = pc_cond_i;    cond = pc_cond_i & gt_i;        end
         6'd6: begin is_br = pc_cond_i;    cond = pc_cond_i & (lt_i | eq_i); end
         6'd1: begin
            if (rt_i == 5'h00 || rt_i == 5'h10) begin
               is_br = pc_cond_i;
               cond  = pc_cond_i & lt_i;
            end else if (rt_i == 5'h01 || rt_i == 5'h11) begin
               is_br = pc_cond_i;
               cond  = pc_cond_i & (gt_i | eq_i);
            end
         end
         default: ;
      endcase
   end

   assign take_o       = pc_write_i | cond;
   assign resolve      = is_br & ~exc_req_i;
   assign pred_taken_o = bht_cur[1];

   always_comb begin
      pc_d = pc_q;
      if (exc_req_i)   pc_d = EXC_VEC;
      else if (take_o) pc_d = next_pc_i;

      link_we_d = resolve & (opcode_i == 6'd1) & rt_i[4];
      link_pc_d = link_we_d ? pc_q : link_pc_q;
      mispred_d = resolve & (cond != bht_cur[1]);

      bht_upd_d = bht_cur;
      if (cond && bht_cur != 2'b11)       bht_upd_d = bht_cur + 2'b01;
      else if (!cond && bht_cur != 2'b00) bht_upd_d = bht_cur - 2'b01;
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         pc_q      <= RESET_PC;
         link_we_q <= 1'b0;
         link_pc_q <= '0;
         mispred_q <= 1'b0;
         for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= 2'b01;
      end else begin
         pc_q      <= pc_d;
         link_we_q <= link_we_d;
         link_pc_q <= link_pc_d;
         mispred_q <= mispred_d;
         if (resolve) bht_q[idx] <= bht_upd_d;
      end
   end

   assign pc_o         = pc_q;
   assign link_we_o    = link_we_q;
   assign link_pc_o    = link_pc_q;
   assign mispredict_o = mispred_q;

`ifdef PC_BRANCH_STATS_EN
   logic [31:0] stat_br_q, stat_mp_q;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         stat_br_q <= '0;
         stat_mp_q <= '0;
      end else begin
         if (resolve && stat_br_q != 32'hFFFF_FFFF)   stat_br_q <= stat_br_q + 32'd1;
         if (mispred_d && stat_mp_q != 32'hFFFF_FFFF) stat_mp_q <= stat_mp_q + 32'd1;
      end
   end

   assign stat_branches_o = stat_br_q;
   assign stat_mispred_o  = stat_mp_q;
`else
   assign stat_branches_o = '0;
   assign stat_mispred_o  = '0;
`endif

endmodule

// File: tb/tb_pc_branch_unit.sv
// Scoreboard bench for pc_branch_unit: a behavioural model predicts each edge's registered outputs.
module tb_pc_branch_unit;
   logic        clk = 0, reset = 1;
   logic [5:0]  opcode = 0;
   logic [4:0]  rt = 0;
   logic        zero = 0, lt = 0, eq = 0, gt = 0;
   logic        pc_write = 0, pc_cond_eq = 0, pc_cond_ne = 0, pc_cond = 0, exc_req = 0;
   logic [31:0] next_pc = 0;
   logic [31:0] pc, link_pc, stat_branches, stat_mispred;
   logic        take, link_we, pred_taken, mispredict;

   pc_branch_unit dut (
      .clk_i(clk), .reset_i(reset), .opcode_i(opcode), .rt_i(rt),
      .zero_i(zero), .lt_i(lt), .eq_i(eq), .gt_i(gt),
      .pc_write_i(pc_write), .pc_cond_eq_i(pc_cond_eq), .pc_cond_ne_i(pc_cond_ne),
      .pc_cond_i(pc_cond), .exc_req_i(exc_req), .next_pc_i(next_pc),
      .pc_o(pc), .take_o(take), .link_we_o(link_we), .link_pc_o(link_pc),
      .pred_taken_o(pred_taken), .mispredict_o(mispredict),
      .stat_branches_o(stat_branches), .stat_mispred_o(stat_mispred)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc, link_pc, sb, sm;
      logic        link_we, mis;
   } exp_t;
   exp_t exp_q[$];

   int checks = 0, failures = 0;
   logic [31:0] pc_m, link_pc_m, sb_m, sm_m;
   logic [1:0]  bht_m [16];

   task automatic chk(string tag, logic [31:0] got, logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h at %0t", tag, got, want, $time);
      end
   endtask

   task automatic model_reset();
      pc_m = 32'h0; link_pc_m = 0; sb_m = 0; sm_m = 0;
      for (int i = 0; i < 16; i++) bht_m[i] = 2'b01;
      exp_q.delete();
   endtask

   // Drive one cycle's inputs, check comb outputs, predict and then check the registered ones
   task automatic cyc(input logic [5:0] op, input logic [4:0] r, input logic z, input logic l,
                      input logic e, input logic g, input logic pw, input logic ceq,
                      input logic cne, input logic cc, input logic ex, input logic [31:0] npc);
      logic c, br, res, pred;
      logic [3:0] ix;
      exp_t x;
      opcode = op; rt = r; zero = z; lt = l; eq = e; gt = g; pc_write = pw;
      pc_cond_eq = ceq; pc_cond_ne = cne; pc_cond = cc; exc_req = ex; next_pc = npc;
      #1;
      c = 0; br = 0;
      if (op == 4)      begin br = ceq; c = ceq & z; end
      else if (op == 5) begin br = cne; c = cne & ~z; end
      else if (op == 7) begin br = cc;  c = cc & g; end
      else if (op == 6) begin br = cc;  c = cc & (l | e); end
      else if (op == 1 && (r == 5'h00 || r == 5'h10)) begin br = cc; c = cc & l; end
      else if (op == 1 && (r == 5'h01 || r == 5'h11)) begin br = cc; c = cc & (g | e); end
      ix   = pc_m[5:2];
      pred = bht_m[ix][1];
      res  = br & ~ex;
      chk("take", {31'b0, take}, {31'b0, pw | c});
      chk("pred_taken", {31'b0, pred_taken}, {31'b0, pred});
      x.link_we = res && op == 1 && r[4];
      if (x.link_we) link_pc_m = pc_m;
      x.link_pc = link_pc_m;
      x.mis = res && (c != pred);
      if (res) begin
         if (c && bht_m[ix] != 2'b11) bht_m[ix] = bht_m[ix] + 2'b01;
         else if (!c && bht_m[ix] != 2'b00) bht_m[ix] = bht_m[ix] - 2'b01;
`ifdef PC_BRANCH_STATS_EN
         sb_m++;
         if (x.mis) sm_m++;
`endif
      end
      pc_m = ex ? 32'hFF : ((pw | c) ? npc : pc_m);
      x.pc = pc_m; x.sb = sb_m; x.sm = sm_m;
      exp_q.push_back(x);
      @(posedge clk); #1;
      if (exp_q.size() == 0) chk("queue_empty", 1, 0);
      else begin
         x = exp_q.pop_front();
         chk("pc", pc, x.pc);
         chk("link_we", {31'b0, link_we}, {31'b0, x.link_we});
         chk("link_pc", link_pc, x.link_pc);
         chk("mispredict", {31'b0, mispredict}, {31'b0, x.mis});
         chk("stat_branches", stat_branches, x.sb);
         chk("stat_mispred", stat_mispred, x.sm);
      end
      @(negedge clk);
   endtask

   task automatic jmp(input logic [31:0] npc);
      cyc(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, npc);
   endtask

   initial begin
      model_reset();
      #2;
      chk("rst_pc", pc, 32'h0);
      chk("rst_link_we", {31'b0, link_we}, 0);
      chk("rst_mispredict", {31'b0, mispredict}, 0);
      chk("rst_stats", stat_branches | stat_mispred, 0);
      @(negedge clk); reset = 0;

      // BEQ taken at 0x40: weak-not-taken prediction mispredicts
      jmp(32'h40);
      cyc(4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h80);
      chk("bht_after_beq", {30'b0, bht_m[0]}, 32'h2);
      // two more taken resolves at 0x40 saturate the counter
      jmp(32'h40); cyc(4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h80);
      jmp(32'h40); cyc(4, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 32'h80);
      chk("bht_saturated", {30'b0, bht_m[0]}, 32'h3);

      // BGEZAL not taken at 0x100: link captured anyway
      jmp(32'h100);
      cyc(1, 5'h11, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h200);
      chk("link_pc_0x100", link_pc, 32'h100);

      // remaining branch kinds, both outcomes
      jmp(32'h104); cyc(5, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 32'h300);
      cyc(5, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 32'h308);
      cyc(7, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h30C);
      cyc(6, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 32'h310);
      cyc(1, 5'h00, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h314);
      cyc(1, 5'h10, 0, 0, 0, 1, 0, 0, 0, 1, 0, 32'h318);
      cyc(1, 5'h03, 0, 1, 0, 0, 0, 0, 0, 1, 0, 32'h31C);
      // pc_write together with a not-taken branch
      cyc(4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'h40);

      // exception beats pc_write and suppresses branch side effects
      cyc(1, 5'h11, 0, 1, 0, 0, 1, 0, 0, 1, 1, 32'h20);
      chk("exc_pc", pc, 32'hFF);

      for (int i = 0; i < 300; i++) begin
         logic [5:0] ops [7];
         logic [4:0] rts [5];
         ops = '{0, 1, 2, 4, 5, 6, 7};
         rts = '{5'h00, 5'h01, 5'h10, 5'h11, 5'h03};
         cyc(ops[$urandom_range(0, 6)], rts[$urandom_range(0, 4)], 1'($urandom), 1'($urandom),
             1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'($urandom), 1'($urandom),
             1'($urandom), ($urandom_range(0, 15) == 0), 32'($urandom_range(0, 255)) << 2);
      end

      // async reset while a link pulse is live
      jmp(32'h200);
      opcode = 1; rt = 5'h10; lt = 1; pc_cond = 1; pc_write = 0; exc_req = 0;
      pc_cond_eq = 0; pc_cond_ne = 0;
      @(posedge clk); #1;
      chk("link_pulse_pre_rst", {31'b0, link_we}, 1);
      #2 reset = 1; #1;
      chk("rst_async_pc", pc, 32'h0);
      chk("rst_async_link_we", {31'b0, link_we}, 0);
      chk("rst_async_mispredict", {31'b0, mispredict}, 0);
      chk("rst_async_stats", stat_branches | stat_mispred, 0);
      model_reset();
      @(negedge clk); reset = 0;
      for (int i = 0; i < 16; i++) jmp(32'(i) << 2);
      jmp(32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1);
   end
endmodule
